// File: rtl/stage_f_if.sv
// Instruction-memory channel between the fetch stage and instruction memory.
// Request side is valid/ready; response side is valid-only, in order, and
// cannot be back-pressured.
interface stage_f_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/stage_f.sv
// stage_f: fetch stage of the combined ARM/RISC-V pipeline.
// Issues sequential word fetches, buffers up to two returned instructions and
// presents the oldest to decode. Taken-branch redirects flush the buffer and
// discard every response still in flight for the old path.
// Optional feature: define COMBI_MODE_EN to track the ARM/RISC-V mode per
// entry; otherwise armF is tied to RESET_ARM and armTargetE is ignored.
module stage_f #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic        RESET_ARM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    stage_f_if.master   imem,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        armTargetE,
    input  logic        StallF,
    output logic        ValidF,
    output logic [31:0] RDD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        armF
);
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] rpc_q, rpc_d;
    logic [1:0]  osc_q, osc_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  bc_q, bc_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];

    logic [2:0]  credit_used;
    logic        req_fire;
    logic        rsp_live;
    logic        rsp_keep;
    logic        pop;
    logic        unused_bits;

    // Requests are only issued while outstanding + buffered leaves room in the buffer.
    assign credit_used         = {1'b0, osc_q} + {1'b0, bc_q};
    assign imem.imem_req_valid = rst_n && (credit_used < 3'd2);
    assign imem.imem_addr      = fpc_q;

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_live = imem.imem_rsp_valid && (osc_q != 2'd0);
    assign rsp_keep = rsp_live && (drop_q == 2'd0);
    assign ValidF   = (bc_q != 2'd0);
    assign pop      = ValidF && !StallF;

    // Head entry presentation; data outputs are zero when the buffer is empty.
    always_comb begin
        RDD      = '0;
        PCF      = '0;
        PCPlus4F = '0;
        if (ValidF) begin
            RDD      = buf_instr_q[rd_ptr_q];
            PCF      = buf_pc_q[rd_ptr_q];
            PCPlus4F = buf_pc_q[rd_ptr_q] + 32'd4;
        end
    end

    // Next-state: a redirect overrides consume, response and issue bookkeeping.
    always_comb begin
        fpc_d       = fpc_q;
        rpc_d       = rpc_q;
        drop_d      = drop_q;
        bc_d        = bc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        osc_d       = osc_q + {1'b0, req_fire} - {1'b0, rsp_live};
        if (PCSrcE) begin
            fpc_d    = {PCTargetE[31:2], 2'b00};
            rpc_d    = {PCTargetE[31:2], 2'b00};
            drop_d   = osc_d;
            bc_d     = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (req_fire) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (rsp_live && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            if (rsp_keep) begin
                buf_instr_d[wr_ptr_q] = imem.imem_rdata;
                buf_pc_d[wr_ptr_q]    = rpc_q;
                wr_ptr_d              = ~wr_ptr_q;
                rpc_d                 = rpc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            bc_d = bc_q + {1'b0, rsp_keep} - {1'b0, pop};
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q       <= RESET_PC_W;
            rpc_q       <= RESET_PC_W;
            osc_q       <= 2'd0;
            drop_q      <= 2'd0;
            bc_q        <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_instr_q <= '{default: '0};
            buf_pc_q    <= '{default: '0};
        end else begin
            fpc_q       <= fpc_d;
            rpc_q       <= rpc_d;
            osc_q       <= osc_d;
            drop_q      <= drop_d;
            bc_q        <= bc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

`ifdef COMBI_MODE_EN
    logic fmode_q, fmode_d;
    logic buf_arm_q [2];
    logic buf_arm_d [2];

    // Mode follows the redirect; each kept response is tagged with the current mode.
    always_comb begin
        fmode_d   = fmode_q;
        buf_arm_d = buf_arm_q;
        if (PCSrcE) begin
            fmode_d = armTargetE;
        end else if (rsp_keep) begin
            buf_arm_d[wr_ptr_q] = fmode_q;
        end
    end

    // Mode state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmode_q   <= RESET_ARM;
            buf_arm_q <= '{default: 1'b0};
        end else begin
            fmode_q   <= fmode_d;
            buf_arm_q <= buf_arm_d;
        end
    end

    assign armF        = ValidF ? buf_arm_q[rd_ptr_q] : fmode_q;
    assign unused_bits = ^PCTargetE[1:0];
`else
    assign armF        = RESET_ARM;
    assign unused_bits = ^{PCTargetE[1:0], armTargetE};
`endif

    // Memory must never return data for a request that was not made.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem.imem_rsp_valid && (osc_q == 2'd0)));
endmodule

// File: tb/tb_stage_f.sv
`timescale 1ns/1ps
module tb_stage_f;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        armTargetE;
    logic        StallF;
    logic        ValidF;
    logic [31:0] RDD;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        armF;

    stage_f_if imem_if ();

    stage_f dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem_if),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .armTargetE (armTargetE),
        .StallF     (StallF),
        .ValidF     (ValidF),
        .RDD        (RDD),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .armF       (armF)
    );

    always #5 clk = ~clk;

`ifdef COMBI_MODE_EN
    localparam logic COMBI = 1'b1;
`else
    localparam logic COMBI = 1'b0;
`endif

    typedef struct { logic [31:0] pc; logic arm; logic stale; } os_t;
    typedef struct { logic [31:0] pc; logic arm; } be_t;
    typedef struct { int due; logic [31:0] addr; } mr_t;

    os_t         os_q[$];
    be_t         bq[$];
    mr_t         mq[$];
    logic [31:0] seen[$];
    logic [31:0] m_fpc;
    logic        m_mode;
    int          cyc;
    int          lat;
    int          checks;
    int          errors;

    logic        s_rst, s_stall, s_ready, s_redir, s_arm;
    logic [31:0] s_target;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event cycle=%0d", name, cyc);
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step();
        logic rsp, fire, exp_rv, exp_vf, pop;
        os_t  o;
        @(negedge clk);
        cyc++;
        rst_n                  = s_rst;
        StallF                 = s_stall;
        imem_if.imem_req_ready = s_ready;
        PCSrcE                 = s_redir;
        PCTargetE              = s_target;
        armTargetE             = s_arm;
        rsp = 1'b0;
        if (!s_rst) mq.delete();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp = 1'b1;
            imem_if.imem_rdata = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_if.imem_rdata = 32'hDEAD_BEEF;
        end
        imem_if.imem_rsp_valid = rsp;
        #1;
        exp_rv = s_rst && ((os_q.size() + bq.size()) < 2);
        exp_vf = (bq.size() != 0);
        chk("req_valid", imem_if.imem_req_valid, exp_rv);
        chk("imem_addr", imem_if.imem_addr, m_fpc);
        chk("ValidF", ValidF, exp_vf);
        if (exp_vf) begin
            chk("RDD", RDD, instr_of(bq[0].pc));
            chk("PCF", PCF, bq[0].pc);
            chk("PCPlus4F", PCPlus4F, bq[0].pc + 32'd4);
            chk("armF", armF, bq[0].arm);
        end else begin
            chk("RDD_idle", RDD, 32'h0);
            chk("PCF_idle", PCF, 32'h0);
            chk("PCPlus4F_idle", PCPlus4F, 32'h0);
            chk("armF_idle", armF, m_mode);
        end
        fire = imem_if.imem_req_valid && s_ready;
        if (fire) mq.push_back('{cyc + lat, imem_if.imem_addr});
        if (ValidF && !s_stall) seen.push_back(PCF);
        if (!s_rst) begin
            os_q.delete();
            bq.delete();
            m_fpc  = 32'h0;
            m_mode = 1'b0;
        end else if (s_redir) begin
            if (rsp && os_q.size() > 0) void'(os_q.pop_front());
            bq.delete();
            foreach (os_q[i]) os_q[i].stale = 1'b1;
            if (exp_rv && s_ready) os_q.push_back('{m_fpc, m_mode, 1'b1});
            m_fpc = s_target & 32'hFFFF_FFFC;
            if (COMBI) m_mode = s_arm;
        end else begin
            pop = exp_vf && !s_stall;
            if (pop) void'(bq.pop_front());
            if (rsp && os_q.size() > 0) begin
                o = os_q.pop_front();
                if (!o.stale) bq.push_back('{o.pc, o.arm});
            end
            if (exp_rv && s_ready) begin
                os_q.push_back('{m_fpc, m_mode, 1'b0});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic wait_valid(input string name, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ValidF) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout_fail(name);
    endtask

    initial begin
        logic [31:0] held_pc, held_addr;
        logic        ok;
        int          n;
        checks = 0; errors = 0; cyc = 0; lat = 1;
        m_fpc = 32'h0; m_mode = 1'b0;
        rst_n = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; armTargetE = 1'b0;
        imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b0; imem_if.imem_rdata = '0;
        s_rst = 1'b0; s_stall = 1'b0; s_ready = 1'b1; s_redir = 1'b0; s_arm = 1'b0; s_target = '0;

        repeat (3) step();
        chk("rst_req_valid", imem_if.imem_req_valid, 32'd0);
        chk("rst_imem_addr", imem_if.imem_addr, 32'h0);
        chk("rst_ValidF", ValidF, 32'd0);
        chk("rst_armF", armF, 32'd0);

        // Release with 1-cycle memory: ValidF rises two cycles after release.
        s_rst = 1'b1;
        step();
        chk("rel_req_valid", imem_if.imem_req_valid, 32'd1);
        chk("rel_ValidF0", ValidF, 32'd0);
        step();
        chk("rel_ValidF1", ValidF, 32'd0);
        step();
        chk("rel_ValidF2", ValidF, 32'd1);
        chk("rel_PCF", PCF, 32'h0);
        chk("rel_PCPlus4F", PCPlus4F, 32'h4);
        repeat (6) step();
        if (seen.size() >= 3) begin
            chk("seq_pc0", seen[0], 32'h0);
            chk("seq_pc1", seen[1], 32'h4);
            chk("seq_pc2", seen[2], 32'h8);
        end else begin
            timeout_fail("seq_first_three");
        end

        // Decode stall for 5 cycles: head held, issue stops once full.
        s_stall = 1'b1;
        repeat (2) step();
        chk("stall_ValidF", ValidF, 32'd1);
        held_pc = PCF;
        repeat (3) step();
        chk("stall_req_valid", imem_if.imem_req_valid, 32'd0);
        chk("stall_PCF_held", PCF, held_pc);
        s_stall = 1'b0;
        repeat (10) step();
        n = seen.size();
        for (int i = 0; i < n; i++) chk("stall_no_loss", seen[i], 32'(4 * i));

        // Memory not ready for 3 cycles: address held, buffer drains.
        s_ready = 1'b0;
        step();
        held_addr = imem_if.imem_addr;
        repeat (2) step();
        chk("noready_addr_held", imem_if.imem_addr, held_addr);
        chk("noready_drained", ValidF, 32'd0);
        s_ready = 1'b1;
        repeat (4) step();

        // 3-cycle memory, redirect to 0x100 with two requests outstanding.
        lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (os_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout_fail("redir_setup");
        s_redir = 1'b1; s_target = 32'h100;
        step();
        s_redir = 1'b0;
        step();
        chk("redir_ValidF_next", ValidF, 32'd0);
        chk("redir_addr_next", imem_if.imem_addr, 32'h100);
        wait_valid("redir_wait", ok);
        if (ok) begin
            chk("redir_PCF", PCF, 32'h100);
            chk("redir_RDD", RDD, instr_of(32'h100));
        end
        repeat (4) step();

        // Redirect coinciding with a response and a request handshake.
        lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (os_q.size() == 1 && bq.size() == 0 && mq.size() > 0 && mq[0].due <= cyc + 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout_fail("same_cycle_setup");
        s_redir = 1'b1; s_target = 32'h300;
        step();
        s_redir = 1'b0;
        wait_valid("same_cycle_wait", ok);
        if (ok) chk("same_cycle_PCF", PCF, 32'h300);
        repeat (4) step();

        // Redirect to 0x200 in ARM mode.
        s_redir = 1'b1; s_target = 32'h200; s_arm = 1'b1;
        step();
        s_redir = 1'b0;
        wait_valid("arm_wait", ok);
        if (ok) begin
            chk("arm_PCF", PCF, 32'h200);
            chk("arm_armF", armF, {31'd0, COMBI});
        end
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
